ecc_hamming_decoder: RTL and testbench
======================================

Name: ecc_hamming_decoder

Overview:
Pipelined Hamming SEC/SECDED decoder, the receive-side counterpart of ecc_hamming_encoder; consumes codeword + extra_parity and returns corrected data with error flags.
- 2-stage pipeline: S1 computes syndrome and overall parity; S2 corrects, extracts data and flags.
- Valid/ready handshake on both sides; sits between a memory/link read port and the consumer.

Parameters:
D, 4, data width in bits
C, 7, codeword width; must equal D+P, where P is a localparam = smallest P with 2^P >= D+P+1
SECDED, 1, 1 = use extra_parity for double-error detection; 0 = plain SEC

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input codeword valid
in_ready  out  1  decoder can accept input
codeword  in  C  received codeword; bit k = Hamming position k+1
extra_parity  in  1  received overall parity; ignored when SECDED=0
out_valid  out  1  output valid
out_ready  in  1  consumer accepts output
dout  out  D  decoded (corrected when possible) data
single_err  out  1  single-bit error detected and corrected
double_err  out  1  uncorrectable error detected
err_pos  out  $clog2(C+1)  syndrome; position corrected; 0 = none or extra_parity bit

Behaviour:
- Code layout, matching ecc_hamming_encoder:
  - Parity bits sit at power-of-two positions 1, 2, 4, ...
  - Data fills the remaining positions in ascending order, din[0] first.
  - extra_parity = XOR of all C codeword bits (even parity).
- S1, on handshake (in_valid & in_ready):
  - Syndrome s[j] = XOR of received bits whose position has bit j set.
  - pmis = XOR(codeword) ^ extra_parity; pmis is forced to 0 when SECDED=0.
  - Register codeword, s, pmis.
- S2 classification, SECDED=1:
  - s==0, pmis==0: clean.
  - s!=0, pmis==1, s<=C: flip bit s-1, single_err=1.
  - s==0, pmis==1: extra_parity bit in error, data unchanged, single_err=1.
  - s!=0, pmis==0: double_err=1, data passed uncorrected.
  - s>C: double_err=1, data uncorrected.
- S2 classification, SECDED=0:
  - s!=0, s<=C: correct, single_err=1.
  - s>C: double_err=1.
- single_err and double_err are never both 1.
- dout, flags and err_pos are registered in S2 and held stable while out_valid & ~out_ready.
- Latency: 2 cycles from input handshake to out_valid with no backpressure; throughput 1/cycle.
- Stage valid bits:
  - A stage loads when it is empty or its content moves downstream in the same cycle.
  - in_ready = ~s1_valid | (~s2_valid | out_ready).
  - in_ready is combinational from out_ready; no combinational in_valid->out_valid path.
- Full backpressure holds 2 entries with no loss or duplication; out_ready deasserted indefinitely keeps out_valid=1 and data stable.
- Reset, including mid-operation: all valid bits, dout, flags and err_pos go to 0 immediately; in-flight words are discarded; in_ready=1 after reset release.

Optional Feature:
- ECC_DEC_CNT_EN defined:
  - Adds outputs sec_cnt[15:0] and ded_cnt[15:0] and input cnt_clr.
  - Counters increment on each output handshake with single_err or double_err respectively.
  - Counters saturate at 16'hFFFF.
  - cnt_clr clears both counters synchronously; a clear in the same cycle as an increment wins (result 0).
  - Reset value is 0.
- ECC_DEC_CNT_EN undefined: counter ports and logic are absent.

Test Plan:
- Clean word, D=4: codeword=7'b1010101, extra_parity=0 (din 4'b1011) -> dout=4'b1011, flags 0, err_pos=0, out_valid exactly 2 cycles after input handshake.
- Single error: codeword=7'b1000101 (position 5 flipped), extra_parity=0 -> dout=4'b1011, single_err=1, err_pos=5.
- Double error: codeword=7'b1010110 (positions 1 and 2 flipped), extra_parity=0 -> double_err=1, single_err=0, err_pos=3, dout=4'b1011 (raw data bits).
- Parity-bit error: codeword=7'b1010101, extra_parity=1 -> dout=4'b1011, single_err=1, err_pos=0.
- Exhaustive plus backpressure: all 16 data values through the encoder, each with 0, 1 and 2 bit flips; out_ready randomly toggled -> every word delivered in order once, correct classification; with out_ready=0, in_ready falls after 2 accepted words.
- Reset with 2 words in flight -> out_valid=0 immediately and no stale output afterwards; with ECC_DEC_CNT_EN, 3 single errors then cnt_clr -> sec_cnt reads 3 then 0.

Source files
------------

// File: rtl/ecc_hamming_decoder.sv
// Two-stage pipelined Hamming SEC/SECDED decoder with valid/ready on both sides.
// Define ECC_DEC_CNT_EN to add saturating SEC/DED event counters with cnt_clr.
module ecc_hamming_decoder #(
  parameter int D      = 4,
  parameter int C      = 7,
  parameter bit SECDED = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [C-1:0]           codeword,
  input  logic                   extra_parity,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [D-1:0]           dout,
  output logic                   single_err,
  output logic                   double_err,
`ifdef ECC_DEC_CNT_EN
  input  logic                   cnt_clr,
  output logic [15:0]            sec_cnt,
  output logic [15:0]            ded_cnt,
`endif
  output logic [$clog2(C+1)-1:0] err_pos
);

  function automatic int calc_p(input int d);
    int p;
    p = 1;
    while ((1 << p) < d + p + 1) p++;
    return p;
  endfunction

  function automatic int dpos(input int i);
    int n;
    int r;
    n = 0;
    r = 0;
    for (int p = 1; p <= C; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == i) r = p;
        n++;
      end
    end
    return r;
  endfunction

  localparam int P  = calc_p(D);
  localparam int EW = $clog2(C + 1);
  localparam logic [P-1:0] CMAX = P'(C);

  logic [P-1:0] w_syn;
  logic         w_par;
  logic         w_pmis;
  logic [D-1:0] w_raw;
  logic [D-1:0] w_data;
  logic         w_nz;
  logic         w_oor;
  logic         w_fix;
  logic         w_sec;
  logic         w_ded;
  logic         w_s1_ld;
  logic         w_s2_ld;

  logic          r_s1_valid;
  logic [D-1:0]  r_s1_data;
  logic [P-1:0]  r_s1_syn;
  logic          r_s1_pmis;
  logic          r_s2_valid;
  logic [D-1:0]  r_dout;
  logic          r_sec;
  logic          r_ded;
  logic [EW-1:0] r_pos;

  always_comb begin
    w_syn = '0;
    w_par = 1'b0;
    for (int k = 0; k < C; k++) begin
      w_par = w_par ^ codeword[k];
      for (int j = 0; j < P; j++)
        if ((((k + 1) >> j) & 1) != 0)
          w_syn[j] = w_syn[j] ^ codeword[k];
    end
  end

  assign w_pmis = SECDED ? (w_par ^ extra_parity) : 1'b0;

  // only data positions travel to S2; parity bits are consumed by the syndrome
  for (genvar i = 0; i < D; i++) begin : g_dat
    localparam int POS = dpos(i);
    assign w_raw[i]  = codeword[POS-1];
    assign w_data[i] = r_s1_data[i]
                     ^ (w_fix && (r_s1_syn == P'(POS)));
  end

  assign w_nz  = |r_s1_syn;
  assign w_oor = r_s1_syn > CMAX;

  always_comb begin
    w_fix = 1'b0;
    w_sec = 1'b0;
    w_ded = 1'b0;
    unique case (1'b1)
      w_oor: w_ded = 1'b1;
      !w_oor && w_nz && (r_s1_pmis || !SECDED): begin
        w_fix = 1'b1;
        w_sec = 1'b1;
      end
      !w_nz && r_s1_pmis: w_sec = 1'b1;
      !w_oor && w_nz && !r_s1_pmis && SECDED: w_ded = 1'b1;
      default: ;
    endcase
  end

  assign w_s2_ld  = ~r_s2_valid | out_ready;
  assign w_s1_ld  = ~r_s1_valid | w_s2_ld;
  assign in_ready = w_s1_ld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_syn   <= '0;
      r_s1_pmis  <= 1'b0;
    end else if (w_s1_ld) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= w_raw;
        r_s1_syn  <= w_syn;
        r_s1_pmis <= w_pmis;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_dout     <= '0;
      r_sec      <= 1'b0;
      r_ded      <= 1'b0;
      r_pos      <= '0;
    end else if (w_s2_ld) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_dout <= w_data;
        r_sec  <= w_sec;
        r_ded  <= w_ded;
        r_pos  <= EW'(r_s1_syn);
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign dout       = r_dout;
  assign single_err = r_sec;
  assign double_err = r_ded;
  assign err_pos    = r_pos;

`ifdef ECC_DEC_CNT_EN
  logic [15:0] r_sec_cnt;
  logic [15:0] r_ded_cnt;
  logic        w_out_hs;

  assign w_out_hs = r_s2_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (cnt_clr) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else begin
      if (w_out_hs && r_sec && (r_sec_cnt != 16'hFFFF))
        r_sec_cnt <= r_sec_cnt + 16'd1;
      if (w_out_hs && r_ded && (r_ded_cnt != 16'hFFFF))
        r_ded_cnt <= r_ded_cnt + 16'd1;
    end
  end

  assign sec_cnt = r_sec_cnt;
  assign ded_cnt = r_ded_cnt;
`endif

endmodule

// File: tb/tb_ecc_hamming_decoder.sv
// Self-checking bench for ecc_hamming_decoder (D=4, C=7, SECDED=1).
// Directed vectors, a randomized backpressured stream, and reset cases.
module tb_ecc_hamming_decoder;

  localparam int D = 4;
  localparam int C = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [C-1:0] codeword = '0;
  logic         extra_parity = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [D-1:0] dout;
  logic         single_err;
  logic         double_err;
  logic [2:0]   err_pos;
`ifdef ECC_DEC_CNT_EN
  logic         cnt_clr = 1'b0;
  logic [15:0]  sec_cnt;
  logic [15:0]  ded_cnt;
`endif

  always #5 clk = ~clk;

  ecc_hamming_decoder #(.D(D), .C(C), .SECDED(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .codeword     (codeword),
    .extra_parity (extra_parity),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .dout         (dout),
    .single_err   (single_err),
    .double_err   (double_err),
`ifdef ECC_DEC_CNT_EN
    .cnt_clr      (cnt_clr),
    .sec_cnt      (sec_cnt),
    .ded_cnt      (ded_cnt),
`endif
    .err_pos      (err_pos)
  );

  typedef struct {
    logic [6:0] cw;
    logic       ep;
    logic [3:0] dout;
    logic       sec;
    logic       ded;
    logic [2:0] pos;
  } vec_t;

  typedef struct {
    logic [3:0] din;
    logic [7:0] mask;
  } item_t;

  int    errs = 0;
  int    checks = 0;
  vec_t  tbl[9];
  vec_t  exp_q[$];
  item_t items[$];
  vec_t  cur;
  vec_t  e;
  bit    hs = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, ".dout"}, 32'(dout), 32'(v.dout));
    chk({tag, ".sec"}, 32'(single_err), 32'(v.sec));
    chk({tag, ".ded"}, 32'(double_err), 32'(v.ded));
    chk({tag, ".pos"}, 32'(err_pos), 32'(v.pos));
  endtask

  // Encode din, flip the positions in mask (bit 0 = extra parity),
  // and predict the decoder's answer from the number of flips.
  function automatic vec_t model(input logic [3:0] din,
                                 input logic [7:0] mask);
    vec_t       v;
    logic [7:0] w;
    logic       ep;
    logic       b;
    int         n;
    int         syn;
    w = '0;
    n = 0;
    for (int p = 1; p < 8; p++)
      if ((p & (p - 1)) != 0) begin
        w[p] = din[n];
        n++;
      end
    for (int p = 1; p < 8; p = p * 2) begin
      b = 1'b0;
      for (int q = 1; q < 8; q++)
        if ((q & p) != 0 && q != p) b = b ^ w[q];
      w[p] = b;
    end
    ep = ^w[7:1];
    w[7:1] = w[7:1] ^ mask[7:1];
    ep = ep ^ mask[0];
    syn = 0;
    for (int p = 1; p < 8; p++)
      if (mask[p]) syn = syn ^ p;
    v.cw  = w[7:1];
    v.ep  = ep;
    v.pos = 3'(syn);
    v.sec = ($countones(mask) == 1);
    v.ded = ($countones(mask) == 2);
    v.dout = din;
    if (v.ded) begin
      n = 0;
      for (int p = 1; p < 8; p++)
        if ((p & (p - 1)) != 0) begin
          v.dout[n] = w[p];
          n++;
        end
    end
    return v;
  endfunction

  function automatic logic [7:0] gen_mask(input int nflip);
    logic [7:0] m;
    m = '0;
    while ($countones(m) < nflip) m[$urandom_range(0, 7)] = 1'b1;
    return m;
  endfunction

  task automatic apply_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    codeword = v.cw;
    extra_parity = v.ep;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 6) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd2);
    chk_out(tag, v);
  endtask

  task automatic present_random();
    cur = model(4'($urandom), gen_mask($urandom_range(0, 2)));
    codeword = cur.cw;
    extra_parity = cur.ep;
    in_valid = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int sent;
    int rcvd;
    int cyc;
    int acc;
    bit seen;

    tbl[0] = '{7'b1010101, 1'b0, 4'b1011, 1'b0, 1'b0, 3'd0};
    tbl[1] = '{7'b1000101, 1'b0, 4'b1011, 1'b1, 1'b0, 3'd5};
    tbl[2] = '{7'b1010110, 1'b0, 4'b1011, 1'b0, 1'b1, 3'd3};
    tbl[3] = '{7'b1010101, 1'b1, 4'b1011, 1'b1, 1'b0, 3'd0};
    tbl[4] = '{7'b1010100, 1'b0, 4'b1011, 1'b1, 1'b0, 3'd1};
    tbl[5] = '{7'b0010101, 1'b0, 4'b1011, 1'b1, 1'b0, 3'd7};
    tbl[6] = '{7'b1010001, 1'b1, 4'b1010, 1'b0, 1'b1, 3'd3};
    tbl[7] = '{7'b0000000, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0};
    tbl[8] = '{7'b1000000, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd7};

    repeat (2) @(negedge clk);
    #1;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.dout", 32'(dout), 32'd0);
    chk("reset.flags", 32'({single_err, double_err}), 32'd0);
    chk("reset.err_pos", 32'(err_pos), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      apply_vec(tbl[i], $sformatf("vec%0d", i));

    // every data value with 0, 1 and 2 flips, then random words
    for (int d = 0; d < 16; d++)
      for (int f = 0; f < 3; f++)
        items.push_back('{4'(d), gen_mask(f)});
    for (int i = 0; i < 60; i++)
      items.push_back('{4'($urandom), gen_mask($urandom_range(0, 2))});
    n = items.size();
    sent = 0;
    rcvd = 0;
    cyc = 0;
    hs = 1'b0;
    in_valid = 1'b0;
    while (rcvd < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (!in_valid || hs) begin
        if (sent < n && $urandom_range(0, 3) != 0) begin
          cur = model(items[sent].din, items[sent].mask);
          codeword = cur.cw;
          extra_parity = cur.ep;
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      hs = in_valid && in_ready;
      if (hs) begin
        exp_q.push_back(cur);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream.unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk_out($sformatf("stream%0d", rcvd), e);
        end
        rcvd++;
      end
    end
    chk("stream.count", 32'(rcvd), 32'(n));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      seen = seen | out_valid;
    end
    chk("stream.no_dup", 32'(seen), 32'd0);

    // full backpressure: exactly two words absorbed
    exp_q.delete();
    hs = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (!in_valid || hs) present_random();
      #1;
      hs = in_valid && in_ready;
      if (hs) begin
        exp_q.push_back(cur);
        acc++;
      end
    end
    chk("bp.accepted", 32'(acc), 32'd2);
    chk("bp.in_ready", 32'(in_ready), 32'd0);
    chk("bp.out_valid", 32'(out_valid), 32'd1);
    chk_out("bp.hold", exp_q[0]);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    hs = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        chk_out("bp.drain", e);
      end
      @(negedge clk);
      cyc++;
    end
    chk("bp.left", 32'(exp_q.size()), 32'd0);

    // reset with two words in flight
    hs = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (!in_valid || hs) present_random();
      #1;
      hs = in_valid && in_ready;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("rst.pre_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.outs", 32'({dout, single_err, double_err, err_pos}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("rst.in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      seen = seen | out_valid;
    end
    chk("rst.no_stale", 32'(seen), 32'd0);
    apply_vec(tbl[1], "post_rst");

`ifdef ECC_DEC_CNT_EN
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) apply_vec(tbl[1], "cnt");
    @(negedge clk);
    #1;
    chk("cnt.sec3", 32'(sec_cnt), 32'd3);
    chk("cnt.ded0", 32'(ded_cnt), 32'd0);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1 chk("cnt.clr", 32'(sec_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
